// File: rtl/pio_ctrl_arb.sv
// pio_ctrl_arb: boots one pio instance from the program/config ROMs, then
// shares its action/din port between four requesters with round-robin pushes.
module pio_ctrl_arb #(
  parameter int PROG_LEN = 32,
  parameter int CONF_LEN = 6,
  parameter int STALL_W  = 8
) (
  input  logic               clk_25mhz,
  input  logic               reset,
  output logic [4:0]         prog_addr,
  input  logic [15:0]        prog_data,
  output logic [4:0]         conf_addr,
  input  logic [37:0]        conf_data,
  input  logic               reload,
  input  logic [3:0]         req_valid,
  input  logic [127:0]       req_data,
  output logic [3:0]         req_ready,
  input  logic [3:0]         tx_full,
  output logic [3:0]         action,
  output logic [31:0]        din,
  output logic [4:0]         index,
  output logic [1:0]         mindex,
  output logic               running,
  output logic [STALL_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {LOAD, CONF, RUN, GAP} state_t;

  localparam logic [3:0] ACT_NOP   = 4'd0;
  localparam logic [3:0] ACT_LOAD  = 4'd1;
  localparam logic [3:0] ACT_PUSH  = 4'd4;
  localparam logic [4:0] PROG_LAST = 5'(PROG_LEN - 1);
  localparam logic [4:0] CONF_LAST = 5'(CONF_LEN - 1);

  state_t      state, state_nxt;
  logic [4:0]  pindex, pindex_nxt;
  logic [4:0]  cindex, cindex_nxt;
  logic [1:0]  last_grant, last_grant_nxt;
  logic        reload_pend, reload_pend_nxt;
  logic [3:0]  action_nxt;
  logic [31:0] din_nxt;
  logic [4:0]  index_nxt;
  logic [1:0]  mindex_nxt;
  logic [3:0]  eligible;
  logic [1:0]  grant;
  logic        grant_valid;
  logic        stalled;

  assign prog_addr = pindex;
  assign conf_addr = cindex;
  assign eligible  = req_valid & ~tx_full;
  assign running   = (state == RUN) || (state == GAP);
  assign stalled   = running && (|(req_valid & tx_full));

  // Search from the largest offset down so the nearest eligible requester after last_grant wins.
  always_comb begin
    grant       = last_grant;
    grant_valid = 1'b0;
    for (int k = 4; k >= 1; k--) begin
      if (eligible[2'(last_grant + 2'(k))]) begin
        grant       = 2'(last_grant + 2'(k));
        grant_valid = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt       = state;
    pindex_nxt      = pindex;
    cindex_nxt      = cindex;
    last_grant_nxt  = last_grant;
    reload_pend_nxt = reload_pend;
    action_nxt      = ACT_NOP;
    din_nxt         = din;
    index_nxt       = index;
    mindex_nxt      = mindex;
    req_ready       = 4'b0000;
    unique case (state)
      LOAD: begin
        action_nxt = ACT_LOAD;
        index_nxt  = pindex;
        din_nxt    = {16'b0, prog_data};
        if (pindex == PROG_LAST) begin
          pindex_nxt = 5'd0;
          state_nxt  = CONF;
        end else begin
          pindex_nxt = pindex + 5'd1;
        end
      end
      CONF: begin
        mindex_nxt = conf_data[37:36];
        action_nxt = conf_data[35:32];
        din_nxt    = conf_data[31:0];
        if (cindex == CONF_LAST) begin
          cindex_nxt = 5'd0;
          state_nxt  = RUN;
        end else begin
          cindex_nxt = cindex + 5'd1;
        end
      end
      RUN: begin
        if (reload_pend || reload) begin
          reload_pend_nxt = 1'b0;
          state_nxt       = LOAD;
        end else if (grant_valid) begin
          req_ready      = 4'b0001 << grant;
          action_nxt     = ACT_PUSH;
          mindex_nxt     = grant;
          din_nxt        = req_data[{grant, 5'b00000} +: 32];
          last_grant_nxt = grant;
          state_nxt      = GAP;
        end
      end
      GAP: begin
        // A reload seen here is deferred so the push just issued is not disturbed.
        if (reload) reload_pend_nxt = 1'b1;
        state_nxt = RUN;
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      state       <= LOAD;
      pindex      <= 5'd0;
      cindex      <= 5'd0;
      last_grant  <= 2'd3;
      reload_pend <= 1'b0;
      action      <= ACT_NOP;
      din         <= 32'd0;
      index       <= 5'd0;
      mindex      <= 2'd0;
      stall_cnt   <= '0;
    end else begin
      state       <= state_nxt;
      pindex      <= pindex_nxt;
      cindex      <= cindex_nxt;
      last_grant  <= last_grant_nxt;
      reload_pend <= reload_pend_nxt;
      action      <= action_nxt;
      din         <= din_nxt;
      index       <= index_nxt;
      mindex      <= mindex_nxt;
      if (stalled && (stall_cnt != '1)) stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end

endmodule

// File: tb/tb_pio_ctrl_arb.sv
// tb_pio_ctrl_arb: self-checking bench for pio_ctrl_arb covering boot sequencing,
// round-robin pushes, stall counting, reload and mid-load reset.
`timescale 1ns/1ps
module tb_pio_ctrl_arb;

  localparam int PROG_LEN  = 32;
  localparam int CONF_LEN  = 6;
  localparam int STALL_W   = 8;
  localparam int STALL_MAX = (1 << STALL_W) - 1;

  typedef struct {
    logic [3:0] v;
    logic [3:0] f;
    logic [3:0] ready;
    logic [3:0] act;
    logic [1:0] mi;
  } vec_t;

  logic               clk_25mhz = 1'b0;
  logic               reset = 1'b1;
  logic [4:0]         prog_addr;
  logic [15:0]        prog_data;
  logic [4:0]         conf_addr;
  logic [37:0]        conf_data;
  logic               reload = 1'b0;
  logic [3:0]         req_valid = 4'b0;
  logic [127:0]       req_data = 128'b0;
  logic [3:0]         req_ready;
  logic [3:0]         tx_full = 4'b0;
  logic [3:0]         action;
  logic [31:0]        din;
  logic [4:0]         index;
  logic [1:0]         mindex;
  logic               running;
  logic [STALL_W-1:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model of the run phase: last winner, whether the last cycle pushed, stall count.
  int m_last  = 3;
  bit m_gap   = 1'b0;
  int m_stall = 0;

  vec_t tbl[$];
  logic [127:0] lane_data = {32'h33, 32'h32, 32'h31, 32'h30};

  always #20 clk_25mhz = ~clk_25mhz;

  // ROM contents are plain functions of the address so the bench can recompute them.
  assign prog_data = 16'hA000 + 16'(prog_addr);
  assign conf_data = {conf_addr[1:0], 4'(conf_addr + 5'd2), 32'hC0F0_0000 + 32'(conf_addr)};

  pio_ctrl_arb #(.PROG_LEN(PROG_LEN), .CONF_LEN(CONF_LEN), .STALL_W(STALL_W)) dut (
    .clk_25mhz(clk_25mhz), .reset(reset),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .conf_addr(conf_addr), .conf_data(conf_data),
    .reload(reload), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_full(tx_full),
    .action(action), .din(din), .index(index), .mindex(mindex),
    .running(running), .stall_cnt(stall_cnt)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic [3:0] f, input logic [127:0] data, input logic rl);
    req_valid = v;
    tx_full   = f;
    req_data  = data;
    reload    = rl;
  endtask

  task automatic add_vec(input logic [3:0] v, input logic [3:0] f, input logic [3:0] r,
                         input logic [3:0] a, input logic [1:0] m);
    vec_t e;
    e.v = v; e.f = f; e.ready = r; e.act = a; e.mi = m;
    tbl.push_back(e);
  endtask

  function automatic int model_grant(input logic [3:0] v, input logic [3:0] f, input int last);
    for (int off = 1; off <= 4; off++) begin
      int cand = (last + off) % 4;
      if (v[cand] && !f[cand]) return cand;
    end
    return -1;
  endfunction

  // One run-phase cycle, checked either against the model or against a table record.
  task automatic step_run(input logic [3:0] v, input logic [3:0] f, input logic [127:0] data,
                          input bit use_model, input vec_t t);
    int g;
    logic [3:0] e_ready;
    logic [3:0] e_act;
    applyStimulus(v, f, data, 1'b0);
    #1;
    if (use_model) begin
      g = m_gap ? -1 : model_grant(v, f, m_last);
      e_ready = (g >= 0) ? 4'(1 << g) : 4'b0;
      e_act   = (g >= 0) ? 4'd4 : 4'd0;
    end else begin
      g = (t.act == 4'd4) ? int'(t.mi) : -1;
      e_ready = t.ready;
      e_act   = t.act;
    end
    checkOutput("req_ready", req_ready, e_ready);
    checkOutput("running", running, 1);
    if (|(v & f)) m_stall = (m_stall < STALL_MAX) ? m_stall + 1 : STALL_MAX;
    @(posedge clk_25mhz);
    @(negedge clk_25mhz);
    checkOutput("push_action", action, e_act);
    if (g >= 0) begin
      checkOutput("push_mindex", mindex, g);
      checkOutput("push_din", din, data[32*g +: 32]);
      m_last = g;
    end
    checkOutput("stall_cnt", stall_cnt, m_stall);
    m_gap = (g >= 0);
  endtask

  // Entered at a negedge with the DUT in LOAD; reload is pulsed once to show it is ignored.
  task automatic load_sequence(input int n_load, input bit with_conf);
    for (int k = 0; k < n_load; k++) begin
      reload = (k == 5);
      @(posedge clk_25mhz);
      @(negedge clk_25mhz);
      checkOutput("load_action", action, 1);
      checkOutput("load_index", index, k);
      checkOutput("load_din", din, 32'hA000 + k);
      checkOutput("load_running", running, 0);
    end
    reload = 1'b0;
    if (with_conf) begin
      for (int k = 0; k < CONF_LEN; k++) begin
        @(posedge clk_25mhz);
        @(negedge clk_25mhz);
        checkOutput("conf_mindex", mindex, k % 4);
        checkOutput("conf_action", action, (k + 2) % 16);
        checkOutput("conf_din", din, 32'hC0F0_0000 + k);
        checkOutput("conf_running", running, (k == CONF_LEN - 1));
      end
      @(posedge clk_25mhz);
      @(negedge clk_25mhz);
      checkOutput("run_first_action", action, 0);
      checkOutput("run_first_running", running, 1);
      m_gap = 1'b0;
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t none;
    none.v = 0; none.f = 0; none.ready = 0; none.act = 0; none.mi = 0;

    add_vec(4'b0001, 4'b0000, 4'b0001, 4'd4, 2'd0);
    add_vec(4'b0001, 4'b0000, 4'b0000, 4'd0, 2'd0);
    add_vec(4'b0001, 4'b0000, 4'b0001, 4'd4, 2'd0);
    add_vec(4'b0000, 4'b0000, 4'b0000, 4'd0, 2'd0);
    add_vec(4'b1111, 4'b0000, 4'b0010, 4'd4, 2'd1);
    add_vec(4'b1111, 4'b0000, 4'b0000, 4'd0, 2'd0);
    add_vec(4'b1111, 4'b0000, 4'b0100, 4'd4, 2'd2);
    add_vec(4'b1111, 4'b0000, 4'b0000, 4'd0, 2'd0);
    add_vec(4'b1111, 4'b0000, 4'b1000, 4'd4, 2'd3);
    add_vec(4'b1111, 4'b0000, 4'b0000, 4'd0, 2'd0);
    add_vec(4'b1111, 4'b0000, 4'b0001, 4'd4, 2'd0);
    add_vec(4'b1111, 4'b0000, 4'b0000, 4'd0, 2'd0);
    for (int i = 0; i < 5; i++) begin
      add_vec(4'b0011, 4'b0001, 4'b0010, 4'd4, 2'd1);
      add_vec(4'b0011, 4'b0001, 4'b0000, 4'd0, 2'd0);
    end
    add_vec(4'b0011, 4'b0000, 4'b0001, 4'd4, 2'd0);
    add_vec(4'b0000, 4'b0000, 4'b0000, 4'd0, 2'd0);
    add_vec(4'b0000, 4'b1111, 4'b0000, 4'd0, 2'd0);
    add_vec(4'b0100, 4'b0100, 4'b0000, 4'd0, 2'd0);
    add_vec(4'b1100, 4'b0100, 4'b1000, 4'd4, 2'd3);
    add_vec(4'b0000, 4'b0000, 4'b0000, 4'd0, 2'd0);

    repeat (3) @(negedge clk_25mhz);
    checkOutput("reset_action", action, 0);
    checkOutput("reset_din", din, 0);
    checkOutput("reset_index", index, 0);
    checkOutput("reset_mindex", mindex, 0);
    checkOutput("reset_running", running, 0);
    checkOutput("reset_stall", stall_cnt, 0);
    checkOutput("reset_ready", req_ready, 0);
    checkOutput("reset_prog_addr", prog_addr, 0);
    checkOutput("reset_conf_addr", conf_addr, 0);

    reset = 1'b0;
    load_sequence(PROG_LEN, 1'b1);

    foreach (tbl[i]) step_run(tbl[i].v, tbl[i].f, lane_data, 1'b0, tbl[i]);

    for (int i = 0; i < 150; i++)
      step_run(4'($urandom_range(0, 15)), 4'($urandom() & $urandom()),
               {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b1, none);

    for (int i = 0; i < 300; i++) step_run(4'b1111, 4'b1111, lane_data, 1'b1, none);
    checkOutput("stall_saturated", stall_cnt, STALL_MAX);

    // Reload in GAP is deferred: the next RUN cycle refuses a valid request, then boot repeats.
    step_run(4'b0001, 4'b0000, lane_data, 1'b1, none);
    applyStimulus(4'b0001, 4'b0000, lane_data, 1'b1);
    #1;
    checkOutput("gap_ready", req_ready, 0);
    @(posedge clk_25mhz);
    @(negedge clk_25mhz);
    reload = 1'b0;
    #1;
    checkOutput("reload_run_ready", req_ready, 0);
    checkOutput("reload_run_running", running, 1);
    checkOutput("reload_run_action", action, 0);
    @(posedge clk_25mhz);
    @(negedge clk_25mhz);
    req_valid = 4'b0000;
    checkOutput("reload_to_load_action", action, 0);
    checkOutput("reload_to_load_running", running, 0);
    load_sequence(PROG_LEN, 1'b1);
    checkOutput("stall_kept_over_reload", stall_cnt, m_stall);

    // Reload in RUN acts at once, then reset aborts the load at pindex 10.
    applyStimulus(4'b0001, 4'b0000, lane_data, 1'b1);
    #1;
    checkOutput("run_reload_ready", req_ready, 0);
    @(posedge clk_25mhz);
    @(negedge clk_25mhz);
    applyStimulus(4'b0000, 4'b0000, lane_data, 1'b0);
    checkOutput("run_reload_running", running, 0);
    load_sequence(10, 1'b0);
    reset = 1'b1;
    @(posedge clk_25mhz);
    @(negedge clk_25mhz);
    checkOutput("midreset_action", action, 0);
    checkOutput("midreset_stall", stall_cnt, 0);
    checkOutput("midreset_index", index, 0);
    checkOutput("midreset_din", din, 0);
    checkOutput("midreset_running", running, 0);
    reset = 1'b0;
    m_last = 3; m_gap = 1'b0; m_stall = 0;
    load_sequence(PROG_LEN, 1'b1);

    for (int i = 0; i < 40; i++)
      step_run(4'($urandom_range(0, 15)), 4'($urandom() & $urandom()),
               {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b1, none);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
